hack_rom_loader: RTL

- Sequences the Hack instruction ROM between two requesters: the HPS ioctl download channel, which writes the program, and the CPU fetch port, which reads it.
- Holds the CPU in reset while a load is in progress and for a fixed settle period afterwards.
- Optionally zero-fills the ROM words that the download did not write.
- Sits between hps_io, the CPU and a single-port synchronous ROM32K RAM.

---
 rtl/hack_pkg.sv | 16 +
 rtl/hack_reset_stretch.sv | 27 ++
 rtl/hack_rom_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack ROM loader.
package hack_pkg;

  localparam int HACK_ROM_AW = 15;
  localparam int HACK_WORD_W = 16;

  localparam logic [HACK_WORD_W-1:0] HACK_CLEAR_WORD = 16'h0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    HOLD  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/hack_reset_stretch.sv
// CPU reset stretcher: counts CYCLES clocks after restart drops, then flags done.
module hack_reset_stretch #(
  parameter int CYCLES = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic restart,
  output logic done
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // done marks the last of the CYCLES held cycles, so the caller leaves on it
  assign done = !restart && (cnt == CW'(CYCLES - 1));

  // Counter runs from 0 while not restarted and parks at the terminal count
  always_ff @(posedge clk_sys) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hack_rom_loader.sv
// Hack ROM loader: arbitrates the ROM32K port between the hps_io download
// channel and CPU instruction fetch, and holds the CPU in reset meanwhile.
// Optional zero-fill of unwritten words: define HACK_LOADER_CLEAR_EN.
//
// state | meaning
// RUN   | CPU fetches from ROM, cpu_reset low
// LOAD  | download active, each accepted strobe committed one cycle later
// CLEAR | zero-fill words from word_count up to the top of ROM
// HOLD  | CPU held in reset for RELEASE_CYCLES while ROM prefetches pc
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int ROM_AW         = HACK_ROM_AW,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [HACK_WORD_W-1:0] ioctl_dout,
  output logic                   ioctl_wait,
  input  logic [ROM_AW-1:0]      pc,
  output logic [HACK_WORD_W-1:0] instruction,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic [HACK_WORD_W-1:0] rom_din,
  output logic                   rom_we,
  input  logic [HACK_WORD_W-1:0] rom_dout,
  output logic                   cpu_reset,
  output logic [ROM_AW:0]        word_count,
  output logic                   overflow
);

  loader_state_e state, state_next;

  logic                   pend_valid;
  logic [ROM_AW-1:0]      pend_addr;
  logic [HACK_WORD_W-1:0] pend_data;
  logic                   rel_done;
  logic                   addr_unused;

  // Byte address to word address; odd byte lane is ignored
  logic [ROM_AW-1:0] w;
  logic [ROM_AW:0]   w_inc;
  logic              in_range;
  logic              accept;
  logic              enter_load;

  assign w           = ioctl_addr[ROM_AW:1];
  assign w_inc       = {1'b0, w} + {{ROM_AW{1'b0}}, 1'b1};
  assign in_range    = (ioctl_addr[24:ROM_AW+1] == '0);
  assign accept      = (state == LOAD) && ioctl_wr && in_range;
  assign enter_load  = (state != LOAD) && (state_next == LOAD);
  assign addr_unused = ioctl_addr[0];

`ifdef HACK_LOADER_CLEAR_EN
  logic [ROM_AW-1:0] clr_ptr;
`endif

  hack_reset_stretch #(
    .CYCLES (RELEASE_CYCLES)
  ) u_reset_stretch (
    .clk_sys (clk_sys),
    .reset   (reset),
    .restart (state != HOLD),
    .done    (rel_done)
  );

  // State register, pending write capture and load bookkeeping
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= HOLD;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
`ifdef HACK_LOADER_CLEAR_EN
      clr_ptr    <= '0;
`endif
    end else begin
      state      <= state_next;
      pend_valid <= accept;
      if (accept) begin
        pend_addr <= w;
        pend_data <= ioctl_dout;
      end
      if (enter_load) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end else if ((state == LOAD) && ioctl_wr) begin
        if (!in_range) begin
          overflow <= 1'b1;
        end else if (w_inc > word_count) begin
          word_count <= w_inc;
        end
      end
`ifdef HACK_LOADER_CLEAR_EN
      // word_count is final by the LOAD exit cycle, so the pointer lands on it
      if (state == LOAD) begin
        clr_ptr <= word_count[ROM_AW-1:0];
      end else if (state == CLEAR) begin
        clr_ptr <= clr_ptr + ROM_AW'(1);
      end
`endif
    end
  end

  // Next state and ROM port steering
  always_comb begin
    state_next = state;
    rom_addr   = pc;
    rom_din    = pend_data;
    rom_we     = 1'b0;
    ioctl_wait = 1'b0;
    case (state)
      RUN: begin
        if (ioctl_download) state_next = LOAD;
      end
      LOAD: begin
        if (pend_valid) begin
          rom_we     = 1'b1;
          rom_addr   = pend_addr;
          ioctl_wait = 1'b1;
        end
        // A strobe coincident with the download fall keeps us here one more cycle
        if (!ioctl_download && !(ioctl_wr && in_range)) begin
`ifdef HACK_LOADER_CLEAR_EN
          state_next = word_count[ROM_AW] ? HOLD : CLEAR;
`else
          state_next = HOLD;
`endif
        end
      end
`ifdef HACK_LOADER_CLEAR_EN
      CLEAR: begin
        if (ioctl_download) begin
          state_next = LOAD;
        end else begin
          rom_we   = 1'b1;
          rom_din  = HACK_CLEAR_WORD;
          rom_addr = clr_ptr;
          if (clr_ptr == '1) state_next = HOLD;
        end
      end
`endif
      HOLD: begin
        if (ioctl_download) state_next = LOAD;
        else if (rel_done)  state_next = RUN;
      end
      default: state_next = HOLD;
    endcase
    // A write still pending when reset hits must not reach the ROM
    if (reset) begin
      rom_we     = 1'b0;
      ioctl_wait = 1'b0;
    end
  end

  assign cpu_reset   = reset || (state != RUN);
  assign instruction = (!reset && (state == RUN)) ? rom_dout : '0;

endmodule
